// File: rtl/mvau_pkg.sv
// Shared constants and helpers for the MVAU weight streamer.
package mvau_pkg;

    localparam int PASS_CNT_W = 16;
    localparam int FIFO_DEPTH = 2;

    // Next read address of a weight pass, wrapping to 0 after depth-1.
    function automatic logic [31:0] addr_wrap(
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        if (addr >= depth - 32'd1) begin
            return 32'd0;
        end
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/mvau_wstream_fifo.sv
// Two-entry register FIFO carrying {last, data} words toward the compute stage.
module mvau_wstream_fifo #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push at full is accepted only together with a pop; the head slot
    // being vacated is exactly the one the write pointer addresses.
    assign w_push = push & (~full | pop);
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mvau_weight_streamer.sv
// Weight-memory read sequencer feeding the MVAU as a valid/ready stream.
// Define MVAU_WSTREAM_STALL_CNT_EN to add the stall_cnt output.
module mvau_weight_streamer
    import mvau_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    en,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_data,
    output logic [SIMD*TW-1:0]      m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
`ifdef MVAU_WSTREAM_STALL_CNT_EN
    output logic [31:0]             stall_cnt,
`endif
    output logic [PASS_CNT_W-1:0]   pass_cnt
);

    typedef logic [SIMD*TW-1:0] wword_t;

    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR =
        WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [WMEM_ADDR_BW-1:0] r_addr;
    logic                    r_rd_vld;
    logic                    r_last_tag;
    logic [PASS_CNT_W-1:0]   r_pass_cnt;

    logic                    w_pop;
    logic                    w_issue;
    logic                    w_full;
    logic                    w_empty;
    logic [1:0]              w_fifo_cnt;
    logic [1:0]              w_occ;
    logic [SIMD*TW:0]        w_fifo_din;
    logic [SIMD*TW:0]        w_fifo_dout;
    wword_t                  w_head;
    logic                    w_head_last;

    assign w_pop = ~w_empty & m_tready;

    // Occupancy counts buffered words plus the read in flight, so an issue
    // always has a FIFO slot waiting for it one cycle later.
    assign w_occ   = w_fifo_cnt + {1'b0, r_rd_vld};
    assign w_issue = en & ((w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr     <= '0;
            r_rd_vld   <= 1'b0;
            r_last_tag <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_last_tag <= (r_addr == LAST_ADDR);
                r_addr     <= WMEM_ADDR_BW'(
                    addr_wrap(32'(r_addr), 32'(WMEM_DEPTH)));
            end
        end
    end

    assign w_fifo_din = {r_last_tag, wmem_data};

    mvau_wstream_fifo #(
        .W (SIMD*TW + 1)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (r_rd_vld),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_cnt)
    );

    assign w_head      = w_fifo_dout[SIMD*TW-1:0];
    assign w_head_last = w_fifo_dout[SIMD*TW];

    assign wmem_addr = r_addr;
    assign m_tdata   = w_head;
    assign m_tlast   = w_head_last;
    assign m_tvalid  = ~w_empty;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pass_cnt <= '0;
        end else if (w_pop & w_head_last) begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
        end
    end

    assign pass_cnt = r_pass_cnt;

`ifdef MVAU_WSTREAM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_stall_cnt <= '0;
        end else if (~w_empty & ~m_tready & ~(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // A read landing in a full FIFO without a pop would drop a word.
    a_no_overflow: assert property (
        @(posedge aclk) disable iff (areset)
        !(w_full & r_rd_vld & ~w_pop)
    );

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Directed bench for mvau_weight_streamer: depth-4 stream plus a depth-1 instance.
`timescale 1ns/1ps
module tb_mvau_weight_streamer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        en, tready;
    logic        en1, tready1;
    logic [3:0]  waddr, waddr1;
    logic [7:0]  wdata, wdata1;
    logic [7:0]  tdata, tdata1;
    logic        tvalid, tvalid1;
    logic        tlast, tlast1;
    logic [15:0] pass, pass1;
`ifdef MVAU_WSTREAM_STALL_CNT_EN
    logic [31:0] stall, stall1;
`endif

    logic [7:0] mem  [16];
    logic [7:0] mem1 [16];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 aclk = ~aclk;

    always @(posedge aclk) wdata  <= mem[waddr];
    always @(posedge aclk) wdata1 <= mem1[waddr1];

    mvau_weight_streamer #(
        .SIMD(8), .TW(1), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .en        (en),
        .wmem_addr (waddr),
        .wmem_data (wdata),
        .m_tdata   (tdata),
        .m_tvalid  (tvalid),
        .m_tready  (tready),
        .m_tlast   (tlast),
`ifdef MVAU_WSTREAM_STALL_CNT_EN
        .stall_cnt (stall),
`endif
        .pass_cnt  (pass)
    );

    mvau_weight_streamer #(
        .SIMD(8), .TW(1), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4)
    ) dut1 (
        .aclk      (aclk),
        .areset    (areset),
        .en        (en1),
        .wmem_addr (waddr1),
        .wmem_data (wdata1),
        .m_tdata   (tdata1),
        .m_tvalid  (tvalid1),
        .m_tready  (tready1),
        .m_tlast   (tlast1),
`ifdef MVAU_WSTREAM_STALL_CNT_EN
        .stall_cnt (stall1),
`endif
        .pass_cnt  (pass1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_w;
        int diff;
        logic [3:0] prev;
        logic acc;
        int n_xfer;

        areset = 1'b1;
        en = 1'b0; tready = 1'b0;
        en1 = 1'b0; tready1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = (i < 4) ? 8'(i + 1) : 8'hEE;
            mem1[i] = (i == 0) ? 8'hA5 : 8'h00;
        end
        @(negedge aclk);
        @(negedge aclk);

        // reset state
        chk("rst addr",   32'(waddr),  32'd0);
        chk("rst valid",  32'(tvalid), 32'd0);
        chk("rst last",   32'(tlast),  32'd0);
        chk("rst data",   32'(tdata),  32'd0);
        chk("rst pass",   32'(pass),   32'd0);
        chk("rst valid1", 32'(tvalid1), 32'd0);
`ifdef MVAU_WSTREAM_STALL_CNT_EN
        chk("rst stall",  stall, 32'd0);
`endif

        // 1: continuous stream, first valid two cycles after first issue
        areset = 1'b0; en = 1'b1; tready = 1'b1;
        @(negedge aclk);
        chk("t1 latency", 32'(tvalid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            chk("t1 valid", 32'(tvalid), 32'd1);
            chk("t1 data",  32'(tdata),  32'((k % 4) + 1));
            chk("t1 last",  32'(tlast),  32'((k % 4) == 3));
        end
        @(negedge aclk);
        chk("t1 pass", 32'(pass),  32'd2);
        chk("t1 wrap", 32'(tdata), 32'd1);

        // 2: five stalled cycles, address freezes, order resumes
        tready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge aclk);
            chk("t2 hold data", 32'(tdata),  32'd1);
            chk("t2 hold vld",  32'(tvalid), 32'd1);
            chk("t2 hold addr", 32'(waddr),  32'd2);
        end
`ifdef MVAU_WSTREAM_STALL_CNT_EN
        chk("t2 stall", stall, 32'd5);
`endif
        tready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge aclk);
            chk("t2 data", 32'(tdata), 32'(k));
            chk("t2 last", 32'(tlast), 32'(k == 4));
        end
        @(negedge aclk);
        chk("t2 data", 32'(tdata), 32'd1);
        chk("t2 pass", 32'(pass),  32'd3);
`ifdef MVAU_WSTREAM_STALL_CNT_EN
        chk("t2 stall hold", stall, 32'd5);
`endif

        // 3: ready toggling; head holds word 1, one read in flight
        exp_w = 1; diff = 2; prev = waddr; n_xfer = 0;
        for (int c = 0; c < 16; c++) begin
            tready = ((c % 2) == 0);
            acc = tvalid & tready;
            if (acc) begin
                chk("t3 data", 32'(tdata), 32'(exp_w));
                chk("t3 last", 32'(tlast), 32'(exp_w == 4));
                exp_w = (exp_w == 4) ? 1 : exp_w + 1;
                n_xfer++;
            end
            @(negedge aclk);
            if (waddr != prev) diff++;
            prev = waddr;
            if (acc) diff--;
            chk("t3 outstanding", 32'(diff <= 2), 32'd1);
        end
        chk("t3 xfers", 32'(n_xfer), 32'd8);

        // 4: reset while one word buffered and one read in flight
        tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        chk("t4 valid", 32'(tvalid), 32'd0);
        chk("t4 pass",  32'(pass),   32'd0);
        chk("t4 addr",  32'(waddr),  32'd0);
        chk("t4 last",  32'(tlast),  32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("t4 lat", 32'(tvalid), 32'd0);
        @(negedge aclk);
        chk("t4 first vld",  32'(tvalid), 32'd1);
        chk("t4 first data", 32'(tdata),  32'd1);
        chk("t4 pass0",      32'(pass),   32'd0);
        @(negedge aclk);
        chk("t4 data2", 32'(tdata), 32'd2);
        chk("t4 addr3", 32'(waddr), 32'd3);

        // 5: en low for three cycles: words 2 and 3 drain, then idle
        en = 1'b0;
        @(negedge aclk);
        chk("t5 drain data", 32'(tdata),  32'd3);
        chk("t5 drain vld",  32'(tvalid), 32'd1);
        @(negedge aclk);
        chk("t5 empty", 32'(tvalid), 32'd0);
        chk("t5 addr",  32'(waddr),  32'd3);
        @(negedge aclk);
        chk("t5 idle", 32'(tvalid), 32'd0);
        en = 1'b1;
        @(negedge aclk);
        chk("t5 restart lat", 32'(tvalid), 32'd0);
        @(negedge aclk);
        chk("t5 resume data", 32'(tdata),  32'd4);
        chk("t5 resume last", 32'(tlast),  32'd1);
        @(negedge aclk);
        chk("t5 next data", 32'(tdata), 32'd1);
        chk("t5 pass",      32'(pass),  32'd1);

        // 6: single-word pass, every word is last
        en1 = 1'b1; tready1 = 1'b1;
        @(negedge aclk);
        chk("t6 lat", 32'(tvalid1), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk("t6 valid", 32'(tvalid1), 32'd1);
            chk("t6 data",  32'(tdata1),  32'hA5);
            chk("t6 last",  32'(tlast1),  32'd1);
            chk("t6 pass",  32'(pass1),   32'(k));
            chk("t6 addr",  32'(waddr1),  32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
